// File: rtl/svpwm_timing.sv
// svpwm_timing: SVPWM sector select, dwell times, overmodulation rescale
// and center-aligned compare values for an up/down PWM counter.
module svpwm_timing #(
  parameter int PERIOD = 2500,
  parameter int KSHIFT = 14
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iSv_en,
  input  logic [15:0] iV1,
  input  logic [15:0] iV2,
  input  logic [15:0] iV3,
  output logic [2:0]  oSector,
  output logic [15:0] oCmp1,
  output logic [15:0] oCmp2,
  output logic [15:0] oCmp3,
  output logic        oBusy,
  output logic        oDone
);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_SEL, S_CHK, S_DIV, S_CALC, S_OUT
  } state_t;

  localparam logic [15:0]        P16  = 16'(PERIOD);
  localparam logic [15:0]        QTR  = 16'(PERIOD / 4);
  localparam logic [16:0]        P17  = 17'(PERIOD);
  localparam logic [31:0]        PU32 = 32'(PERIOD);
  localparam logic signed [31:0] PS32 = 32'(PERIOD);
  localparam logic signed [17:0] PS18 = 18'(PERIOD);

  state_t st_q, st_d;
  logic en_q, en_d;
  logic signed [15:0] v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [17:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [2:0]  n_q, n_d;
  logic [15:0] t1_q, t1_d, t2_q, t2_d;
  logic [16:0] r1_q, r1_d, r2_q, r2_d;
  logic [16:0] s_q, s_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  sec_q, sec_d;
  logic [15:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;

  logic [2:0]  nsel;
  logic signed [17:0] a, b;
  logic [16:0] sum, sh1, sh2;
  logic [31:0] d1, d2;
  logic [15:0] ta, tb, tc;

  function automatic logic signed [17:0] scale(input logic signed [16:0] v);
    logic signed [31:0] p;
    p = {{15{v[16]}}, v};
    p = p * PS32;
    p = p >>> KSHIFT;
    return p[17:0];
  endfunction

  function automatic logic [15:0] clamp(input logic signed [17:0] t);
    if (t < 18'sd0) return 16'd0;
    else if (t > PS18) return P16;
    else return t[15:0];
  endfunction

  always_comb begin
    st_d  = st_q;
    en_d  = iSv_en;
    v1_d  = v1_q;
    v2_d  = v2_q;
    v3_d  = v3_q;
    x_d   = x_q;
    y_d   = y_q;
    z_d   = z_q;
    n_d   = n_q;
    t1_d  = t1_q;
    t2_d  = t2_q;
    r1_d  = r1_q;
    r2_d  = r2_q;
    s_d   = s_q;
    cnt_d = cnt_q;
    sec_d = sec_q;
    c1_d  = c1_q;
    c2_d  = c2_q;
    c3_d  = c3_q;

    nsel = {v3_q > 16'sd0, v2_q > 16'sd0, v1_q > 16'sd0};
    a = '0;
    b = '0;
    case (nsel)
      3'd3: begin a = -z_q; b = x_q;  end
      3'd1: begin a = z_q;  b = y_q;  end
      3'd5: begin a = x_q;  b = -y_q; end
      3'd4: begin a = -x_q; b = z_q;  end
      3'd6: begin a = -y_q; b = -z_q; end
      3'd2: begin a = y_q;  b = -x_q; end
      default: begin a = '0; b = '0; end
    endcase

    sum = {1'b0, t1_q} + {1'b0, t2_q};
    d1  = {16'd0, t1_q} * PU32;
    d2  = {16'd0, t2_q} * PU32;
    sh1 = {r1_q[15:0], t1_q[15]};
    sh2 = {r2_q[15:0], t2_q[15]};
    ta  = (P16 - t1_q - t2_q) >> 2;
    tb  = ta + (t1_q >> 1);
    tc  = tb + (t2_q >> 1);

    unique case (st_q)
      S_IDLE: begin
        if (iSv_en && !en_q) begin
          v1_d = iV1;
          v2_d = iV2;
          v3_d = iV3;
          st_d = S_MUL;
        end
      end
      S_MUL: begin
        x_d  = scale({v1_q[15], v1_q});
        y_d  = scale(-{v3_q[15], v3_q});
        z_d  = scale(-{v2_q[15], v2_q});
        st_d = S_SEL;
      end
      S_SEL: begin
        n_d  = nsel;
        t1_d = clamp(a);
        t2_d = clamp(b);
        st_d = S_CHK;
      end
      S_CHK: begin
        s_d   = sum;
        cnt_d = '0;
        st_d  = S_CALC;
        if (sum > P17) begin
          // Dividend high half seeds the remainder; low half shifts in.
          r1_d = {1'b0, d1[31:16]};
          t1_d = d1[15:0];
          r2_d = {1'b0, d2[31:16]};
          t2_d = d2[15:0];
          st_d = S_DIV;
        end
      end
      S_DIV: begin
        if (sh1 >= s_q) begin
          r1_d = sh1 - s_q;
          t1_d = {t1_q[14:0], 1'b1};
        end else begin
          r1_d = sh1;
          t1_d = {t1_q[14:0], 1'b0};
        end
        if (sh2 >= s_q) begin
          r2_d = sh2 - s_q;
          t2_d = {t2_q[14:0], 1'b1};
        end else begin
          r2_d = sh2;
          t2_d = {t2_q[14:0], 1'b0};
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) st_d = S_CALC;
      end
      S_CALC: begin
        st_d = S_OUT;
        case (n_q)
          3'd3: begin sec_d = 3'd1; c1_d = ta; c2_d = tb; c3_d = tc; end
          3'd1: begin sec_d = 3'd2; c1_d = tb; c2_d = ta; c3_d = tc; end
          3'd5: begin sec_d = 3'd3; c1_d = ta; c2_d = tc; c3_d = tb; end
          3'd4: begin sec_d = 3'd4; c1_d = tc; c2_d = tb; c3_d = ta; end
          3'd6: begin sec_d = 3'd5; c1_d = tc; c2_d = ta; c3_d = tb; end
          3'd2: begin sec_d = 3'd6; c1_d = tb; c2_d = tc; c3_d = ta; end
          default: begin
            sec_d = 3'd0;
            c1_d  = QTR;
            c2_d  = QTR;
            c3_d  = QTR;
          end
        endcase
      end
      S_OUT: st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      st_q  <= S_IDLE;
      en_q  <= 1'b0;
      v1_q  <= '0;
      v2_q  <= '0;
      v3_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      n_q   <= '0;
      t1_q  <= '0;
      t2_q  <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      s_q   <= '0;
      cnt_q <= '0;
      sec_q <= '0;
      c1_q  <= '0;
      c2_q  <= '0;
      c3_q  <= '0;
    end else begin
      st_q  <= st_d;
      en_q  <= en_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
      n_q   <= n_d;
      t1_q  <= t1_d;
      t2_q  <= t2_d;
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      s_q   <= s_d;
      cnt_q <= cnt_d;
      sec_q <= sec_d;
      c1_q  <= c1_d;
      c2_q  <= c2_d;
      c3_q  <= c3_d;
    end
  end

  assign oSector = sec_q;
  assign oCmp1   = c1_q;
  assign oCmp2   = c2_q;
  assign oCmp3   = c3_q;
  assign oDone   = (st_q == S_OUT);
  assign oBusy   = (st_q != S_IDLE) && (st_q != S_OUT);

endmodule

// File: tb/tb_svpwm_timing.sv
// tb_svpwm_timing: directed vector table plus handshake/reset sequences
// for svpwm_timing.
module tb_svpwm_timing;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] v1 = '0, v2 = '0, v3 = '0;
  logic [2:0]  sec;
  logic [15:0] c1, c2, c3;
  logic        busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  svpwm_timing dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .iSv_en (en),
    .iV1    (v1),
    .iV2    (v2),
    .iV3    (v3),
    .oSector(sec),
    .oCmp1  (c1),
    .oCmp2  (c2),
    .oCmp3  (c3),
    .oBusy  (busy),
    .oDone  (done)
  );

  typedef struct {
    string nm;
    int v1, v2, v3;
    int sec, c1, c2, c3, lat;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int s, input int a,
                         input int b, input int c);
    chk({nm, " sector"}, int'(sec), s);
    chk({nm, " cmp1"}, int'(c1), a);
    chk({nm, " cmp2"}, int'(c2), b);
    chk({nm, " cmp3"}, int'(c3), c);
  endtask

  // Called at a negedge with en low for at least one prior cycle.
  task automatic run_vec(input vec_t t);
    int lat;
    lat = 0;
    v1 = 16'(t.v1);
    v2 = 16'(t.v2);
    v3 = 16'(t.v3);
    en = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        en = 1'b0;
        chk({t.nm, " busy"}, int'(busy), 1);
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    chk({t.nm, " latency"}, lat, t.lat);
    chk({t.nm, " busy@done"}, int'(busy), 0);
    chk_out(t.nm, t.sec, t.c1, t.c2, t.c3);
  endtask

  initial begin
    int dn, lat;

    tbl[0]  = '{"zero",     0,      0,      0,      0, 625, 625, 625,  5};
    tbl[1]  = '{"sec1",     4096,   2048,   -6144,  1, 390, 546, 858,  5};
    tbl[2]  = '{"ovm",      16384,  -16384, -16384, 2, 625, 0,   1250, 21};
    tbl[3]  = '{"a30",      4096,   4096,   -8192,  1, 312, 624, 936,  5};
    tbl[4]  = '{"a90",      8192,   -4096,  -4096,  2, 624, 312, 936,  5};
    tbl[5]  = '{"a150",     4096,   -8192,  4096,   3, 312, 936, 624,  5};
    tbl[6]  = '{"a210",     -4096,  -4096,  8192,   4, 936, 624, 312,  5};
    tbl[7]  = '{"a270",     -8192,  4096,   4096,   5, 936, 312, 624,  5};
    tbl[8]  = '{"a330",     -4096,  8192,   -4096,  6, 624, 936, 312,  5};
    tbl[9]  = '{"s2asym",   4096,   -2048,  -6144,  2, 468, 312, 936,  5};
    tbl[10] = '{"s4asym",   -4096,  -2048,  6144,   4, 858, 702, 390,  5};
    tbl[11] = '{"s5asym",   -6144,  2048,   4096,   5, 858, 390, 702,  5};
    tbl[12] = '{"s3div",    16384,  -16384, 8192,   3, 0,   1249, 833, 21};
    tbl[13] = '{"s1clamp",  32767,  32767,  -32768, 1, 0,   625, 1250, 21};
    tbl[14] = '{"deg7",     100,    100,    100,    0, 625, 625, 625,  5};

    repeat (3) @(negedge clk);
    chk_out("reset", 0, 0, 0, 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      run_vec(tbl[i]);
      @(negedge clk);
    end

    // Held-high enable must produce exactly one calculation.
    v1 = 16'(4096); v2 = 16'(2048); v3 = 16'(-6144);
    en = 1'b1;
    dn = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dn++;
    end
    en = 1'b0;
    chk("hold one done", dn, 1);
    chk_out("hold", 1, 390, 546, 858);
    @(negedge clk);

    // Second edge at T+3 with different data is ignored.
    v1 = 16'(-6144); v2 = 16'(2048); v3 = 16'(4096);
    en = 1'b1;
    dn = 0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) en = 1'b0;
      if (n == 2) begin
        en = 1'b1;
        v1 = '0; v2 = '0; v3 = '0;
      end
      if (n == 3) en = 1'b0;
      if (done) begin
        dn++;
        if (lat == 0) lat = n;
      end
    end
    chk("reedge done count", dn, 1);
    chk("reedge latency", lat, 5);
    chk_out("reedge hold", 5, 858, 390, 702);

    // Edge in the cycle right after oDone is accepted.
    v1 = 16'(-4096); v2 = 16'(-2048); v3 = 16'(6144);
    en = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) en = 1'b0;
      if (done) break;
    end
    @(negedge clk);
    run_vec(tbl[3]);

    // Reset mid-division aborts without oDone.
    @(negedge clk);
    v1 = 16'(16384); v2 = 16'(-16384); v3 = 16'(-16384);
    en = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      if (n == 1) en = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    chk_out("midrst", 0, 0, 0, 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dn++;
    end
    chk("midrst no done", dn, 0);
    run_vec(tbl[2]);
    @(negedge clk);
    run_vec(tbl[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
